// File: rtl/wb_stage_pipe_if.sv
// rtl/wb_stage_pipe_if.sv - MEM/WB bundle and register-file write port of the write-back stage
interface wb_stage_pipe_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int OFF_W      = 2,
  parameter int CNT_W      = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  stall;
  logic                  flush;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] rd;
  logic [1:0]            wb_sel;
  logic [DATA_W-1:0]     alu_data_out;
  logic [DATA_W-1:0]     dm_data_out;
  logic [DATA_W-1:0]     link_addr;
  logic [1:0]            load_size;
  logic                  load_unsigned;
  logic [OFF_W-1:0]      byte_off;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic                  misalign_err;
  logic [CNT_W-1:0]      retire_cnt;

  modport master (
    output in_valid, stall, flush, reg_write, rd, wb_sel, alu_data_out, dm_data_out,
           link_addr, load_size, load_unsigned, byte_off,
    input  in_ready, rf_we, rf_waddr, rf_wdata, misalign_err, retire_cnt
  );

  modport slave (
    input  in_valid, stall, flush, reg_write, rd, wb_sel, alu_data_out, dm_data_out,
           link_addr, load_size, load_unsigned, byte_off,
    output in_ready, rf_we, rf_waddr, rf_wdata, misalign_err, retire_cnt
  );
endinterface

// File: rtl/wb_stage_pipe.sv
// rtl/wb_stage_pipe.sv - registered write-back stage: result select, load extend/align check, retire count
module wb_stage_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int OFF_W      = 2,
  parameter int CNT_W      = 32
) (
  input logic          clk,
  input logic          rst_n,
  wb_stage_pipe_if.slave wb
);
  logic [DATA_W-1:0]     lane;
  logic [DATA_W-1:0]     field_mask;
  logic                  sign_bit;
  logic [DATA_W-1:0]     load_data;
  logic                  misaligned;
  logic [DATA_W-1:0]     wb_data;

  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0]     rf_wdata_q;
  logic                  misalign_q, misalign_d;
  logic [CNT_W-1:0]      retire_cnt_q;

  assign wb.in_ready = !wb.stall;

  always_comb begin
    lane       = wb.dm_data_out >> {wb.byte_off, 3'b000};
    field_mask = '1;
    sign_bit   = lane[DATA_W-1];
    misaligned = 1'b0;
    case (wb.load_size)
      2'b00: begin
        field_mask = DATA_W'(8'hFF);
        sign_bit   = lane[7];
      end
      2'b01: begin
        field_mask = DATA_W'(16'hFFFF);
        sign_bit   = lane[15];
        misaligned = wb.byte_off[0];
      end
      2'b10: begin
        field_mask = DATA_W'(32'hFFFF_FFFF);
        sign_bit   = lane[31];
        misaligned = (wb.byte_off[1:0] != 2'b00);
      end
      default: begin
        misaligned = (wb.byte_off != '0);
      end
    endcase
    // Sign extension fills every bit above the extracted field.
    load_data = (lane & field_mask) |
                ((!wb.load_unsigned && sign_bit) ? ~field_mask : '0);
    case (wb.wb_sel)
      2'b01:   wb_data = load_data;
      2'b10:   wb_data = wb.link_addr;
      default: wb_data = wb.alu_data_out;
    endcase
    if (wb.wb_sel != 2'b01) misaligned = 1'b0;
    misalign_d = wb.in_valid && misaligned;
    rf_we_d    = wb.in_valid && wb.reg_write && (wb.rd != '0) && !misaligned;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      misalign_q   <= 1'b0;
      retire_cnt_q <= '0;
    end else if (wb.flush) begin
      rf_we_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else if (!wb.stall) begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= wb.rd;
      rf_wdata_q <= wb_data;
      misalign_q <= misalign_d;
      // Misaligned loads and r0 writes still retire.
      if (wb.in_valid) retire_cnt_q <= retire_cnt_q + 1'b1;
    end
  end

  assign wb.rf_we        = rf_we_q;
  assign wb.rf_waddr     = rf_waddr_q;
  assign wb.rf_wdata     = rf_wdata_q;
  assign wb.misalign_err = misalign_q;
  assign wb.retire_cnt   = retire_cnt_q;
endmodule

// File: tb/tb_wb_stage_pipe.sv
// tb/tb_wb_stage_pipe.sv - bench for wb_stage_pipe, 32-bit (4-bit counter) and 64-bit instances
module tb_wb_stage_pipe;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  wb_stage_pipe_if #(.DATA_W(32), .REG_ADDR_W(5), .OFF_W(2), .CNT_W(4))  i32 ();
  wb_stage_pipe_if #(.DATA_W(64), .REG_ADDR_W(5), .OFF_W(3), .CNT_W(32)) i64 ();

  wb_stage_pipe #(.DATA_W(32), .REG_ADDR_W(5), .OFF_W(2), .CNT_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .wb(i32.slave));
  wb_stage_pipe #(.DATA_W(64), .REG_ADDR_W(5), .OFF_W(3), .CNT_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .wb(i64.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        e_we    [2];
  logic        e_mis   [2];
  logic [4:0]  e_waddr [2];
  logic [63:0] e_wdata [2];
  int          e_cnt   [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int dw, input logic [1:0] sel,
                                input logic [63:0] alu, input logic [63:0] dm,
                                input logic [63:0] link, input logic [1:0] size,
                                input logic uns, input logic [2:0] off,
                                output logic [63:0] data, output logic mis);
    logic [63:0] lane, m;
    int nb;
    mis  = 1'b0;
    data = (sel == 2'd2) ? link : alu;
    if (sel == 2'd1) begin
      nb   = (size == 0) ? 8 : (size == 1) ? 16 : (size == 2) ? 32 : dw;
      lane = dm >> (8 * off);
      m    = (nb == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << nb) - 64'd1);
      data = lane & m;
      if (!uns && lane[nb-1]) data = data | ~m;
      mis = ((int'(off) % (nb / 8)) != 0);
    end
    if (dw == 32) data = data & 64'hFFFF_FFFF;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      e_we[k] = 1'b0; e_mis[k] = 1'b0; e_waddr[k] = '0; e_wdata[k] = '0; e_cnt[k] = 0;
    end
  endtask

  task automatic check_outputs();
    chk("we32",  {63'd0, i32.rf_we},        {63'd0, e_we[0]});
    chk("mis32", {63'd0, i32.misalign_err}, {63'd0, e_mis[0]});
    chk("cnt32", {60'd0, i32.retire_cnt},   64'(e_cnt[0] % 16));
    chk("we64",  {63'd0, i64.rf_we},        {63'd0, e_we[1]});
    chk("mis64", {63'd0, i64.misalign_err}, {63'd0, e_mis[1]});
    chk("cnt64", {32'd0, i64.retire_cnt},   64'(e_cnt[1]));
    if (e_we[0]) begin
      chk("waddr32", {59'd0, i32.rf_waddr}, {59'd0, e_waddr[0]});
      chk("wdata32", {32'd0, i32.rf_wdata}, e_wdata[0]);
    end
    if (e_we[1]) begin
      chk("waddr64", {59'd0, i64.rf_waddr}, {59'd0, e_waddr[1]});
      chk("wdata64", i64.rf_wdata, e_wdata[1]);
    end
  endtask

  task automatic step(input logic v, input logic rw, input logic [4:0] rd,
                      input logic [1:0] sel, input logic [63:0] alu, input logic [63:0] dm,
                      input logic [63:0] link, input logic [1:0] size, input logic uns,
                      input logic [2:0] off, input logic st, input logic fl);
    logic [63:0] d;
    logic        mis;
    i32.in_valid = v;  i32.reg_write = rw; i32.rd = rd; i32.wb_sel = sel;
    i32.alu_data_out = alu[31:0]; i32.dm_data_out = dm[31:0]; i32.link_addr = link[31:0];
    i32.load_size = size; i32.load_unsigned = uns; i32.byte_off = off[1:0];
    i32.stall = st; i32.flush = fl;
    i64.in_valid = v;  i64.reg_write = rw; i64.rd = rd; i64.wb_sel = sel;
    i64.alu_data_out = alu; i64.dm_data_out = dm; i64.link_addr = link;
    i64.load_size = size; i64.load_unsigned = uns; i64.byte_off = off;
    i64.stall = st; i64.flush = fl;
    #1;
    chk("in_ready32", {63'd0, i32.in_ready}, {63'd0, !st});
    for (int k = 0; k < 2; k++) begin
      if (k == 0) model(32, sel, alu, dm & 64'hFFFF_FFFF, link, size, uns, {1'b0, off[1:0]}, d, mis);
      else        model(64, sel, alu, dm, link, size, uns, off, d, mis);
      if (fl) begin
        e_we[k] = 1'b0; e_mis[k] = 1'b0;
      end else if (!st) begin
        e_mis[k]   = v && mis;
        e_we[k]    = v && rw && (rd != 0) && !mis;
        e_waddr[k] = rd;
        e_wdata[k] = d;
        if (v) e_cnt[k]++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  logic [63:0] r_alu, r_dm, r_link;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    clear_model();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_we",    {63'd0, i32.rf_we}, 64'd0);
    chk("rst_wdata", {32'd0, i32.rf_wdata}, 64'd0);
    chk("rst_waddr", {59'd0, i32.rf_waddr}, 64'd0);
    rst_n = 1'b1;

    step(1, 1, 5'd3, 2'b00, 64'd5, 64'd4, 64'd0, 0, 0, 0, 0, 0);
    chk("t1_we", {63'd0, i32.rf_we}, 64'd1);
    chk("t1_waddr", {59'd0, i32.rf_waddr}, 64'd3);
    chk("t1_wdata", {32'd0, i32.rf_wdata}, 64'd5);
    chk("t1_cnt", {60'd0, i32.retire_cnt}, 64'd1);

    step(1, 1, 5'd7, 2'b01, 0, 64'h1234_80FF, 0, 2'b00, 0, 3'd1, 0, 0);
    chk("t2_lbs", {32'd0, i32.rf_wdata}, 64'hFFFF_FF80);
    step(1, 1, 5'd7, 2'b01, 0, 64'h1234_80FF, 0, 2'b00, 1, 3'd1, 0, 0);
    chk("t2_lbu", {32'd0, i32.rf_wdata}, 64'h0000_0080);

    step(1, 1, 5'd8, 2'b01, 0, 64'h1234_5678, 0, 2'b01, 0, 3'd1, 0, 0);
    chk("t3_mis", {63'd0, i32.misalign_err}, 64'd1);
    chk("t3_we", {63'd0, i32.rf_we}, 64'd0);
    chk("t3_cnt", {60'd0, i32.retire_cnt}, 64'd4);
    step(1, 1, 5'd8, 2'b01, 0, 64'hABCD_0000, 0, 2'b01, 0, 3'd2, 0, 0);
    chk("t3_mis_pulse", {63'd0, i32.misalign_err}, 64'd0);
    chk("t3_lh", {32'd0, i32.rf_wdata}, 64'hFFFF_ABCD);

    step(1, 1, 5'd0, 2'b10, 0, 0, 64'h40, 0, 0, 0, 0, 0);
    chk("t4_r0_we", {63'd0, i32.rf_we}, 64'd0);
    chk("t4_r0_cnt", {60'd0, i32.retire_cnt}, 64'd6);
    step(1, 1, 5'd31, 2'b10, 0, 0, 64'h40, 0, 0, 0, 0, 0);
    chk("t4_link", {32'd0, i32.rf_wdata}, 64'h40);
    chk("t4_we", {63'd0, i32.rf_we}, 64'd1);

    for (int i = 0; i < 3; i++) begin
      step(1, 1, 5'(i + 1), 2'b00, 64'(100 + i), 0, 0, 0, 0, 0, 1, 0);
      chk("t5_hold_wdata", {32'd0, i32.rf_wdata}, 64'h40);
      chk("t5_hold_waddr", {59'd0, i32.rf_waddr}, 64'd31);
    end
    step(1, 1, 5'd9, 2'b00, 64'd9, 0, 0, 0, 0, 0, 1, 1);
    chk("t5_flush_we", {63'd0, i32.rf_we}, 64'd0);

    step(1, 1, 5'd4, 2'b11, 64'h77, 0, 64'h99, 0, 0, 0, 0, 0);
    chk("sel11_alu", {32'd0, i32.rf_wdata}, 64'h77);

    step(1, 1, 5'd5, 2'b01, 0, 64'hDEAD_BEEF_0123_4567, 0, 2'b11, 0, 3'd0, 0, 0);
    chk("t6_full64", i64.rf_wdata, 64'hDEAD_BEEF_0123_4567);

    #2;
    rst_n = 1'b0;
    #1;
    chk("async_we32", {63'd0, i32.rf_we}, 64'd0);
    chk("async_wdata32", {32'd0, i32.rf_wdata}, 64'd0);
    chk("async_cnt32", {60'd0, i32.retire_cnt}, 64'd0);
    chk("async_wdata64", i64.rf_wdata, 64'd0);
    chk("async_cnt64", {32'd0, i64.retire_cnt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();

    for (int i = 0; i < 17; i++)
      step(1, 1, 5'(i), 2'b00, 64'(i), 0, 0, 0, 0, 0, 0, 0);
    chk("t6_wrap32", {60'd0, i32.retire_cnt}, 64'd1);
    chk("t6_cnt64", {32'd0, i64.retire_cnt}, 64'd17);

    for (int i = 0; i < 300; i++) begin
      r_alu  = {$urandom, $urandom};
      r_dm   = {$urandom, $urandom};
      r_link = {$urandom, $urandom};
      step(($urandom_range(0, 5) != 0), $urandom_range(0, 1), 5'($urandom_range(0, 31)),
           2'($urandom_range(0, 3)), r_alu, r_dm, r_link, 2'($urandom_range(0, 3)),
           $urandom_range(0, 1), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
Parametrised, registered write-back stage for the pipelined core. It takes the MEM/WB bundle, selects the result source (ALU, data memory or link address), and for loads extracts, sign- or zero-extends and alignment-checks the data. The result is registered once toward the register file and the forwarding unit. The stage also supports stall, flush, r0 write suppression and a retired-instruction counter.

Parameters:
DATA_W, 32, datapath width; legal values 32 or 64
REG_ADDR_W, 5, register index width
OFF_W, 2, byte-offset width; must equal log2(DATA_W/8)
CNT_W, 32, retire counter width

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  MEM stage presents a valid instruction
in_ready  out  1  stage accepts input this cycle; equals !stall
stall  in  1  hold stage register contents
flush  in  1  kill the instruction being captured
reg_write  in  1  instruction writes the register file
rd  in  REG_ADDR_W  destination register
wb_sel  in  2  result source: 00 ALU, 01 memory, 10 link, 11 reserved (treated as ALU)
alu_data_out  in  DATA_W  ALU result
dm_data_out  in  DATA_W  raw data-memory word
link_addr  in  DATA_W  PC+4 for jal/jalr
load_size  in  2  00 byte, 01 half, 10 word(32), 11 full DATA_W
load_unsigned  in  1  1 = zero-extend, 0 = sign-extend
byte_off  in  OFF_W  low address bits of the load
rf_we  out  1  register-file write enable
rf_waddr  out  REG_ADDR_W  write address
rf_wdata  out  DATA_W  write data (wb_data)
misalign_err  out  1  one-cycle pulse: misaligned load retired, write suppressed
retire_cnt  out  CNT_W  count of instructions retired

Behaviour:
- Reset (async on rst_n low): rf_we=0, rf_waddr=0, rf_wdata=0, misalign_err=0, retire_cnt=0, internal valid=0. Asserting reset mid-operation discards the in-flight instruction immediately.
- Latency: 1 cycle. Inputs captured on edge N drive rf_* during cycle N+1.
- Capture occurs when stall=0. When stall=1, all registered outputs hold their values. rf_we stays asserted if it was asserted; the register-file write is idempotent.
- flush=1 at the edge: valid, rf_we and misalign_err are cleared to 0; rf_waddr and rf_wdata are don't-care. Flush overrides stall.
- Memory data extraction for wb_sel=01:
  - Lane = dm_data_out >> (8*byte_off).
  - Byte: low 8 bits of the lane. Half: low 16 bits. Word: low 32 bits. Full: entire DATA_W.
  - Extend to DATA_W with zeros if load_unsigned=1, else with the top bit of the extracted field.
  - When DATA_W=32, load_size 10 and 11 are identical.
- Alignment rules (checked only when wb_sel=01): half requires byte_off[0]=0; word requires byte_off[1:0]=0; full requires byte_off=0.
- On a misaligned load: registered misalign_err=1 for one cycle, rf_we=0, and the instruction still counts as retired.
- rf_we = in_valid & reg_write & (rd!=0) & !misaligned. A write to r0 never asserts rf_we, but the instruction still retires.
- retire_cnt increments by 1 on each edge where in_valid=1, stall=0 and flush=0. It wraps from all-ones to 0 with no flag.
- wb_sel=11 behaves exactly like 00.

Test Plan:
1. Reset, then in_valid=1, reg_write=1, rd=3, wb_sel=00, alu_data_out=5, dm_data_out=4 -> one cycle later rf_we=1, rf_waddr=3, rf_wdata=5, retire_cnt=1.
2. wb_sel=01, dm_data_out=0x1234_80FF, load_size=00, byte_off=1, signed -> rf_wdata=0xFFFF_FF80. Same with load_unsigned=1 -> 0x0000_0080.
3. Half load, byte_off=1 -> misalign_err pulses for 1 cycle, rf_we=0, retire_cnt still increments. Half load, byte_off=2, dm=0xABCD_0000, signed -> rf_wdata=0xFFFF_ABCD.
4. wb_sel=10, link_addr=0x40, rd=0 -> rf_we=0, retire_cnt increments. Repeat with rd=31 -> rf_we=1, rf_wdata=0x40.
5. Stall held 3 cycles while inputs change -> outputs frozen, in_ready=0, retire_cnt unchanged. Assert stall and flush together -> rf_we=0.
6. CNT_W=4: retire 17 instructions -> retire_cnt=1. Drop rst_n mid-stream -> all outputs 0 without waiting for a clock edge. DATA_W=64: full load, byte_off=0 -> 64-bit passthrough.
